thunderbird_seq_n: RTL
======================

THUNDERBIRD_SEQ_N -- requirements
Module: thunderbird_seq_n

Interface
REQ-001 Parameter LAMPS, default 3, lamps per side (legal 2..8).
REQ-002 Parameter DIV, default 12500000, CLOCK_50 cycles per sequence step (4 Hz at 50 MHz); legal 2..2^26.
REQ-003 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 haz  in  1  hazard request, level.
REQ-006 left  in  1  left-turn request, level.
REQ-007 right  in  1  right-turn request, level.
REQ-008 brake  in  1  brake request, level; ignored unless BRAKE_EN is defined.
REQ-009 LL  out  LAMPS  left lamps, registered; bit 0 innermost.
REQ-010 RL  out  LAMPS  right lamps, registered; bit 0 innermost.
REQ-011 tick  out  1  one-cycle step strobe.

Function
REQ-012 Divider counter SHALL count 0..DIV-1 and wrap; tick SHALL be 1 exactly in the cycle where count==DIV-1.
REQ-013 Mode SHALL be decoded at each tick from the inputs sampled in that cycle, with priority: (haz | (left & right)) -> HAZ; left -> LEFT; right -> RIGHT; else IDLE.
REQ-014 Between ticks, state, LL and RL SHALL hold; input changes between ticks SHALL have no effect.
REQ-015 States: IDLE, L1..L(LAMPS), R1..R(LAMPS), HON, HOFF.
REQ-016 IDLE: LL=RL=0; on a tick, goes to HON if HAZ, L1 if LEFT, R1 if RIGHT, else stays in IDLE.
REQ-017 Lk: LL has the low k bits set and RL=0; on a tick with LEFT, goes to L(k+1), or from L(LAMPS) to IDLE (one step with all lamps off before repeating).
REQ-018 Rk: mirror of Lk on RL.
REQ-019 HON: LL=RL=all ones; HOFF: all zero; on a tick with HAZ they alternate HON->HOFF->HON.
REQ-020 Preemption: on a tick whose decoded mode differs from the current sequence, the state SHALL go to IDLE; the new sequence starts at the following tick. Exception: HAZ from any state SHALL go directly to HON.
REQ-021 LL/RL SHALL take the new state's pattern on the same rising edge at which tick=1 (one-step latency from sampling to lamp change).
REQ-022 A request asserted for only one tick SHALL produce exactly one step (L1/R1/HON) and then return to IDLE.

Reset
REQ-023 While reset=1 at a rising edge: count=0, state=IDLE, LL=0, RL=0, tick=0 on the next cycle.
REQ-024 Reset SHALL override a coincident tick; the first tick after release SHALL occur DIV cycles after the release edge.

Configuration
REQ-025 Macro THUNDERBIRD_BRAKE_EN: when defined, with brake=1, any side not currently showing a turn step SHALL be driven all ones (IDLE: both sides on; Lk: RL all ones; Rk: LL all ones; HOFF: both on); a turning side keeps its sequence pattern; brake takes effect at the next tick.
REQ-026 Without THUNDERBIRD_BRAKE_EN, brake SHALL have no effect and the brake logic SHALL not be synthesised.

Verification (LAMPS=3, DIV=4)
REQ-027 Reset, then left=1 held -> on successive ticks LL=001,011,111,000,001...; RL=000 throughout; tick high every 4th cycle.
REQ-028 right=1 held, then right=0 and left=1 while in R2 -> the next tick gives IDLE (000/000), the following tick gives LL=001.
REQ-029 left=right=1 -> HON (111/111), HOFF (000/000), alternating per tick; then haz=1 asserted in L2 -> HON on the next tick.
REQ-030 reset pulsed on a tick cycle while in L3 -> LL=RL=0, count=0; the next tick occurs 4 cycles after release.
REQ-031 left toggled between ticks only (0 at every tick-cycle sample) -> lamps stay 000/000.
REQ-032 THUNDERBIRD_BRAKE_EN defined, brake=1, left=1 -> RL=111 while LL steps 001,011,111,000; brake=0 with the macro undefined -> RL=000.

Source files
------------

// File: rtl/thunderbird_seq_n.sv
// thunderbird_seq_n: Thunderbird-style tail-lamp sequencer.
// A free-running divider produces a one-cycle step strobe. At each strobe the
// request inputs are decoded into a mode (hazard / left / right / idle), and
// the sequencer advances: turn sequences light lamps outward one at a time,
// then take one all-off step before repeating. Hazard blinks both sides.
// A change of mode drops to IDLE for one step before the new sequence
// starts, except hazard, which lights immediately.
// Optional feature macro: THUNDERBIRD_BRAKE_EN (brake lights every side that
// is not currently showing a turn step).
module thunderbird_seq_n #(
  parameter int unsigned LAMPS = 3,
  parameter int unsigned DIV   = 12500000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             haz,
  input  logic             left,
  input  logic             right,
  input  logic             brake,
  output logic [LAMPS-1:0] LL,
  output logic [LAMPS-1:0] RL,
  output logic             tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW = $clog2(LAMPS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEFT,
    S_RIGHT,
    S_HON,
    S_HOFF
  } phase_t;

  logic [CW-1:0]    cnt;
  phase_t           phase;
  phase_t           nphase;
  logic [SW-1:0]    step;
  logic [SW-1:0]    nstep;
  logic [LAMPS-1:0] nll;
  logic [LAMPS-1:0] nrl;
  logic             m_haz;

  // Lamp pattern for turn step k: the k innermost lamps lit.
  function automatic logic [LAMPS-1:0] fill_low(input logic [SW-1:0] k);
    logic [LAMPS-1:0] f;
    f = '0;
    for (int unsigned i = 0; i < LAMPS; i++) begin
      f[i] = (SW'(i) < k);
    end
    return f;
  endfunction

  assign tick  = (cnt == CW'(DIV - 1));
  assign m_haz = haz | (left & right);

  // Next sequence state from current state and the mode decoded this cycle.
  always_comb begin
    nphase = S_IDLE;
    nstep  = '0;
    if (m_haz) begin
      nphase = (phase == S_HON) ? S_HOFF : S_HON;
    end else if (left) begin
      if (phase == S_IDLE) begin
        nphase = S_LEFT;
        nstep  = SW'(1);
      end else if (phase == S_LEFT && step != SW'(LAMPS)) begin
        nphase = S_LEFT;
        nstep  = step + SW'(1);
      end
    end else if (right) begin
      if (phase == S_IDLE) begin
        nphase = S_RIGHT;
        nstep  = SW'(1);
      end else if (phase == S_RIGHT && step != SW'(LAMPS)) begin
        nphase = S_RIGHT;
        nstep  = step + SW'(1);
      end
    end
  end

  // Lamp patterns for the next state, including the optional brake overlay.
  always_comb begin
    nll = '0;
    nrl = '0;
    case (nphase)
      S_LEFT:  nll = fill_low(nstep);
      S_RIGHT: nrl = fill_low(nstep);
      S_HON: begin
        nll = '1;
        nrl = '1;
      end
      default: begin
        nll = '0;
        nrl = '0;
      end
    endcase
`ifdef THUNDERBIRD_BRAKE_EN
    if (brake) begin
      if (nphase != S_LEFT)  nll = '1;
      if (nphase != S_RIGHT) nrl = '1;
    end
`endif
  end

`ifndef THUNDERBIRD_BRAKE_EN
  logic unused_brake;
  assign unused_brake = brake;
`endif

  // Divider, sequence state and registered lamps; everything but the divider
  // holds between strobes, and reset wins over a coincident strobe.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt   <= '0;
      phase <= S_IDLE;
      step  <= '0;
      LL    <= '0;
      RL    <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        phase <= nphase;
        step  <= nstep;
        LL    <= nll;
        RL    <= nrl;
      end
    end
  end

endmodule
